// File: rtl/simps_usb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : simps_usb_pkg
//  Description : Shared types and timing defaults for the FT245-style USB
//                FIFO bridge (state encoding, direction, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package simps_usb_pkg;

  // Timing defaults, all in clk cycles at 25 MHz
  localparam int RD_PULSE_CLKS_DFLT = 2;
  localparam int WR_PULSE_CLKS_DFLT = 2;
  localparam int RECOVER_CLKS_DFLT  = 3;
  localparam int SYNC_STAGES_DFLT   = 2;
  localparam int TX_RD_LATENCY_DFLT = 2;

  // Width of the shared phase down-counter; comfortably covers all timings
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    TX_FETCH  = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5,
    RECOVER   = 3'd6
  } usb_state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } usb_dir_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : STAGES-deep flip-flop synchroniser for a single asynchronous
//                level, with a parameterised reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  generate
    if (STAGES == 1) begin : g_single
      // Single-stage capture of the asynchronous level
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_chain <= RESET_VAL;
        else       r_chain <= d;
      end
    end else begin : g_multi
      // Shift the asynchronous level through the chain, oldest at the top
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_chain <= {STAGES{RESET_VAL}};
        else       r_chain <= {r_chain[STAGES-2:0], d};
      end
    end
  endgenerate

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/usb_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : usb_fifo_bridge
//  Description : Byte mover between an FT245-style asynchronous USB FIFO chip
//                and the on-chip rx/tx FIFOs. One byte per transaction, with
//                round-robin arbitration when both directions are pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_fifo_bridge
  import simps_usb_pkg::*;
#(
  parameter int RD_PULSE_CLKS = RD_PULSE_CLKS_DFLT,
  parameter int WR_PULSE_CLKS = WR_PULSE_CLKS_DFLT,
  parameter int RECOVER_CLKS  = RECOVER_CLKS_DFLT,
  parameter int SYNC_STAGES   = SYNC_STAGES_DFLT,
  parameter int TX_RD_LATENCY = TX_RD_LATENCY_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        usb_rxf_n,
  input  logic        usb_txe_n,
  input  logic [7:0]  usb_d_in,
  output logic [7:0]  usb_d_out,
  output logic        usb_d_oe,
  output logic        usb_rd_n,
  output logic        usb_wr,
  output logic        rx_wr_en,
  output logic [7:0]  rx_wr_data,
  input  logic        rx_full,
  output logic        tx_rd_en,
  input  logic [7:0]  tx_rd_data,
  input  logic        tx_empty,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count,
  output logic        busy
);

  usb_state_t       r_state, w_state_nxt;
  usb_dir_t         r_last_dir, r_cur_dir, w_cur_dir_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic w_rxf_sync_n, w_txe_sync_n;
  logic w_rx_req, w_tx_req, w_cnt_done;
  logic w_rd_done, w_fetch_done, w_wr_done, w_rec_done;

  logic        r_rd_n, r_wr, r_oe, r_rx_wr_en, r_tx_rd_en, r_busy;
  logic [7:0]  r_d_out, r_rx_wr_data;
  logic [15:0] r_rx_count, r_tx_count;

  // Chip status flags are asynchronous; both synchronisers reset to inactive
  sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rxf (
    .clk   (clk),
    .reset (reset),
    .d     (usb_rxf_n),
    .q     (w_rxf_sync_n)
  );

  sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_txe (
    .clk   (clk),
    .reset (reset),
    .d     (usb_txe_n),
    .q     (w_txe_sync_n)
  );

  // Phase length loaded into the shared down-counter on entry to a state.
  // TX_FETCH spans the pop cycle plus the FIFO read latency.
  function automatic logic [CNT_W-1:0] cnt_load(input usb_state_t s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      RD_STROBE: v = CNT_W'(RD_PULSE_CLKS - 1);
      TX_FETCH:  v = CNT_W'(TX_RD_LATENCY);
      WR_STROBE: v = CNT_W'(WR_PULSE_CLKS - 1);
      RECOVER:   v = CNT_W'(RECOVER_CLKS - 1);
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Next-state, arbitration and phase-completion decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_dir_nxt = r_cur_dir;
    w_rd_done     = 1'b0;
    w_fetch_done  = 1'b0;
    w_wr_done     = 1'b0;
    w_rec_done    = 1'b0;
    w_rx_req      = !w_rxf_sync_n && !rx_full;
    w_tx_req      = !w_txe_sync_n && !tx_empty;
    w_cnt_done    = (r_cnt == '0);

    case (r_state)
      IDLE: begin
        // When both sides are pending, serve the one not served last
        if (w_rx_req && (!w_tx_req || r_last_dir == DIR_TX)) begin
          w_state_nxt   = RD_STROBE;
          w_cur_dir_nxt = DIR_RX;
        end else if (w_tx_req) begin
          w_state_nxt   = TX_FETCH;
          w_cur_dir_nxt = DIR_TX;
        end
      end
      RD_STROBE: begin
        if (w_cnt_done) begin
          w_state_nxt = RECOVER;
          w_rd_done   = 1'b1;
        end
      end
      TX_FETCH: begin
        if (w_cnt_done) begin
          w_state_nxt  = WR_SETUP;
          w_fetch_done = 1'b1;
        end
      end
      WR_SETUP: w_state_nxt = WR_STROBE;
      WR_STROBE: begin
        if (w_cnt_done) begin
          w_state_nxt = WR_HOLD;
          w_wr_done   = 1'b1;
        end
      end
      WR_HOLD: w_state_nxt = RECOVER;
      RECOVER: begin
        if (w_cnt_done) begin
          w_state_nxt = IDLE;
          w_rec_done  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Reload on every state change, otherwise count down and park at zero
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = cnt_load(w_state_nxt);
    end else if (!w_cnt_done) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Phase counter and round-robin direction memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_cur_dir  <= DIR_TX;
      r_last_dir <= DIR_TX;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_cur_dir <= w_cur_dir_nxt;
      if (w_rec_done) r_last_dir <= r_cur_dir;
    end
  end

  // Strobes and bus enable registered from the next state so they line up
  // exactly with the state they belong to and never glitch at the pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_n       <= 1'b1;
      r_wr         <= 1'b0;
      r_oe         <= 1'b0;
      r_d_out      <= 8'h00;
      r_rx_wr_en   <= 1'b0;
      r_rx_wr_data <= 8'h00;
      r_tx_rd_en   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rd_n     <= (w_state_nxt != RD_STROBE);
      r_wr       <= (w_state_nxt == WR_STROBE);
      r_oe       <= (w_state_nxt == WR_SETUP) || (w_state_nxt == WR_STROBE) ||
                    (w_state_nxt == WR_HOLD);
      r_tx_rd_en <= (w_state_nxt == TX_FETCH) && (r_state != TX_FETCH);
      r_rx_wr_en <= w_rd_done;
      r_busy     <= (w_state_nxt != IDLE);
      if (w_rd_done)    r_rx_wr_data <= usb_d_in;
      if (w_fetch_done) r_d_out      <= tx_rd_data;
    end
  end

  // Transfer counters, free-running with natural 16-bit wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_count <= 16'h0000;
      r_tx_count <= 16'h0000;
    end else begin
      if (w_rd_done) r_rx_count <= r_rx_count + 16'd1;
      if (w_wr_done) r_tx_count <= r_tx_count + 16'd1;
    end
  end

  assign usb_rd_n   = r_rd_n;
  assign usb_wr     = r_wr;
  assign usb_d_oe   = r_oe;
  assign usb_d_out  = r_d_out;
  assign rx_wr_en   = r_rx_wr_en;
  assign rx_wr_data = r_rx_wr_data;
  assign tx_rd_en   = r_tx_rd_en;
  assign rx_count   = r_rx_count;
  assign tx_count   = r_tx_count;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_fifo_bridge
//  Description : Self-checking bench for usb_fifo_bridge with a behavioural
//                FT245 chip model, a tx FIFO model and a transfer scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_fifo_bridge;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        usb_rxf_n, usb_txe_n;
  logic [7:0]  usb_d_in, usb_d_out;
  logic        usb_d_oe, usb_rd_n, usb_wr;
  logic        rx_wr_en, rx_full, tx_rd_en, tx_empty, busy;
  logic [7:0]  rx_wr_data, tx_rd_data;
  logic [15:0] rx_count, tx_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Chip-side rx byte source and tx FIFO contents, pointer based
  logic [7:0]  chip_rx_mem [256];
  logic [15:0] chip_wr_ptr = 16'd0;
  logic [15:0] chip_rd_ptr = 16'd0;
  logic [7:0]  txf_mem [256];
  logic [15:0] txf_wr_ptr = 16'd0;
  logic [15:0] txf_rd_ptr = 16'd0;
  logic [7:0]  txf_s1 = 8'h00;

  // Observations collected by the monitor
  logic [7:0] rx_got_q [$];
  logic [7:0] tx_got_q [$];
  logic       dir_log  [$];
  int rd_low_cyc = 0, wr_high_cyc = 0, wr_rise = 0, oe_cyc = 0;
  int rx_en_cyc = 0, tx_en_cyc = 0, contention = 0;
  logic prev_wr = 1'b0;

  // Reference counts: number of bytes moved since reset, modulo 2^16
  logic [15:0] exp_rx_count = 16'd0;
  logic [15:0] exp_tx_count = 16'd0;

  usb_fifo_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .usb_rxf_n  (usb_rxf_n),
    .usb_txe_n  (usb_txe_n),
    .usb_d_in   (usb_d_in),
    .usb_d_out  (usb_d_out),
    .usb_d_oe   (usb_d_oe),
    .usb_rd_n   (usb_rd_n),
    .usb_wr     (usb_wr),
    .rx_wr_en   (rx_wr_en),
    .rx_wr_data (rx_wr_data),
    .rx_full    (rx_full),
    .tx_rd_en   (tx_rd_en),
    .tx_rd_data (tx_rd_data),
    .tx_empty   (tx_empty),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .busy       (busy)
  );

  always #20 clk = ~clk;

  assign usb_rxf_n = (chip_rd_ptr == chip_wr_ptr);
  assign usb_d_in  = chip_rx_mem[chip_rd_ptr[7:0]];
  assign tx_empty  = (txf_rd_ptr == txf_wr_ptr);

  // Chip advances to its next byte when the read strobe is released
  always @(posedge usb_rd_n) if (!reset) chip_rd_ptr <= chip_rd_ptr + 16'd1;

  // tx FIFO: data appears two cycles after the pop
  always @(posedge clk) begin
    if (tx_rd_en) begin
      txf_s1     <= txf_mem[txf_rd_ptr[7:0]];
      txf_rd_ptr <= txf_rd_ptr + 16'd1;
    end
    tx_rd_data <= txf_s1;
  end

  // Mid-cycle monitor: strobe widths, pushes, chip latches, contention
  always @(negedge clk) begin
    if (!usb_rd_n)           rd_low_cyc++;
    if (usb_wr)              wr_high_cyc++;
    if (usb_wr && !prev_wr)  wr_rise++;
    if (usb_d_oe)            oe_cyc++;
    if (tx_rd_en)            tx_en_cyc++;
    if (usb_d_oe && !usb_rd_n) contention++;
    if (rx_wr_en) begin
      rx_en_cyc++;
      rx_got_q.push_back(rx_wr_data);
      dir_log.push_back(1'b0);
    end
    if (prev_wr && !usb_wr && !reset) begin
      tx_got_q.push_back(usb_d_out);
      dir_log.push_back(1'b1);
    end
    prev_wr = usb_wr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_rx(input logic [7:0] b);
    chip_rx_mem[chip_wr_ptr[7:0]] = b;
    chip_wr_ptr = chip_wr_ptr + 16'd1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    txf_mem[txf_wr_ptr[7:0]] = b;
    txf_wr_ptr = txf_wr_ptr + 16'd1;
  endtask

  task automatic wait_rx(input int target, input string name);
    for (int i = 0; i < 300 && rx_got_q.size() < target; i++) @(negedge clk);
    n_checks++;
    if (rx_got_q.size() < target)
      $display("FAIL %s_rx_timeout: got %0d bytes, need %0d", name, rx_got_q.size(), target);
    else n_pass++;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input string name);
    for (int i = 0; i < 300 && tx_got_q.size() < target; i++) @(negedge clk);
    n_checks++;
    if (tx_got_q.size() < target)
      $display("FAIL %s_tx_timeout: got %0d bytes, need %0d", name, tx_got_q.size(), target);
    else n_pass++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (usb_rd_n !== 1'b1)    $display("FAIL rst_rd_n: got %b want 1", usb_rd_n); else n_pass++;
    n_checks++; if (usb_wr !== 1'b0)      $display("FAIL rst_wr: got %b want 0", usb_wr); else n_pass++;
    n_checks++; if (usb_d_oe !== 1'b0)    $display("FAIL rst_oe: got %b want 0", usb_d_oe); else n_pass++;
    n_checks++; if (usb_d_out !== 8'h00)  $display("FAIL rst_d_out: got %h want 00", usb_d_out); else n_pass++;
    n_checks++; if (rx_wr_en !== 1'b0)    $display("FAIL rst_rx_wr_en: got %b want 0", rx_wr_en); else n_pass++;
    n_checks++; if (rx_wr_data !== 8'h00) $display("FAIL rst_rx_wr_data: got %h want 00", rx_wr_data); else n_pass++;
    n_checks++; if (tx_rd_en !== 1'b0)    $display("FAIL rst_tx_rd_en: got %b want 0", tx_rd_en); else n_pass++;
    n_checks++; if (rx_count !== 16'h0)   $display("FAIL rst_rx_count: got %h want 0", rx_count); else n_pass++;
    n_checks++; if (tx_count !== 16'h0)   $display("FAIL rst_tx_count: got %h want 0", tx_count); else n_pass++;
    n_checks++; if (busy !== 1'b0)        $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_rx_single();
    int rd0, en0, oe0, n0;
    rd0 = rd_low_cyc; en0 = rx_en_cyc; oe0 = oe_cyc; n0 = rx_got_q.size();
    push_rx(8'hA5);
    wait_rx(n0 + 1, "rx1");
    exp_rx_count = exp_rx_count + 16'd1;
    n_checks++; if (rx_got_q[n0] !== 8'hA5) $display("FAIL rx1_data: got %h want a5", rx_got_q[n0]); else n_pass++;
    n_checks++; if (rd_low_cyc - rd0 != 2) $display("FAIL rx1_rd_width: got %0d want 2", rd_low_cyc - rd0); else n_pass++;
    n_checks++; if (rx_en_cyc - en0 != 1) $display("FAIL rx1_push_width: got %0d want 1", rx_en_cyc - en0); else n_pass++;
    n_checks++; if (oe_cyc - oe0 != 0) $display("FAIL rx1_oe: got %0d cycles want 0", oe_cyc - oe0); else n_pass++;
    n_checks++; if (rx_count !== exp_rx_count) $display("FAIL rx1_count: got %h want %h", rx_count, exp_rx_count); else n_pass++;
  endtask

  task automatic test_tx_single();
    int en0, wr0, oe0, rise0, rd0, n0;
    en0 = tx_en_cyc; wr0 = wr_high_cyc; oe0 = oe_cyc; rise0 = wr_rise; rd0 = rd_low_cyc; n0 = tx_got_q.size();
    push_tx(8'h3C);
    usb_txe_n = 1'b0;
    wait_tx(n0 + 1, "tx1");
    usb_txe_n = 1'b1;
    exp_tx_count = exp_tx_count + 16'd1;
    n_checks++; if (tx_got_q[n0] !== 8'h3C) $display("FAIL tx1_data: got %h want 3c", tx_got_q[n0]); else n_pass++;
    n_checks++; if (tx_en_cyc - en0 != 1) $display("FAIL tx1_pop_width: got %0d want 1", tx_en_cyc - en0); else n_pass++;
    n_checks++; if (wr_high_cyc - wr0 != 2) $display("FAIL tx1_wr_width: got %0d want 2", wr_high_cyc - wr0); else n_pass++;
    n_checks++; if (wr_rise - rise0 != 1) $display("FAIL tx1_wr_strobes: got %0d want 1", wr_rise - rise0); else n_pass++;
    n_checks++; if (oe_cyc - oe0 != 4) $display("FAIL tx1_oe_width: got %0d want 4", oe_cyc - oe0); else n_pass++;
    n_checks++; if (rd_low_cyc - rd0 != 0) $display("FAIL tx1_rd: got %0d cycles want 0", rd_low_cyc - rd0); else n_pass++;
    n_checks++; if (tx_count !== exp_tx_count) $display("FAIL tx1_count: got %h want %h", tx_count, exp_tx_count); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [7:0] rx_exp [6];
    logic [7:0] tx_exp [6];
    int rn0, tn0, dn0;
    @(negedge clk);
    reset = 1'b1;
    exp_rx_count = 16'd0;
    exp_tx_count = 16'd0;
    rn0 = rx_got_q.size(); tn0 = tx_got_q.size(); dn0 = dir_log.size();
    for (int i = 0; i < 6; i++) begin
      rx_exp[i] = 8'($urandom_range(255, 0));
      tx_exp[i] = 8'($urandom_range(255, 0));
      push_rx(rx_exp[i]);
      push_tx(tx_exp[i]);
    end
    usb_txe_n = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_rx(rn0 + 6, "alt");
    wait_tx(tn0 + 6, "alt");
    usb_txe_n = 1'b1;
    exp_rx_count = exp_rx_count + 16'd6;
    exp_tx_count = exp_tx_count + 16'd6;
    n_checks++;
    if (dir_log.size() - dn0 != 12) $display("FAIL alt_txn_count: got %0d want 12", dir_log.size() - dn0);
    else n_pass++;
    for (int i = 0; i < 12 && dn0 + i < dir_log.size(); i++) begin
      n_checks++;
      if (dir_log[dn0 + i] !== i[0]) $display("FAIL alt_order_%0d: got dir %b want %b (0=rx)", i, dir_log[dn0 + i], i[0]);
      else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rx_got_q[rn0 + i] !== rx_exp[i]) $display("FAIL alt_rx_data_%0d: got %h want %h", i, rx_got_q[rn0 + i], rx_exp[i]);
      else n_pass++;
      n_checks++;
      if (tx_got_q[tn0 + i] !== tx_exp[i]) $display("FAIL alt_tx_data_%0d: got %h want %h", i, tx_got_q[tn0 + i], tx_exp[i]);
      else n_pass++;
    end
    n_checks++; if (rx_count !== exp_rx_count) $display("FAIL alt_rx_count: got %h want %h", rx_count, exp_rx_count); else n_pass++;
    n_checks++; if (tx_count !== exp_tx_count) $display("FAIL alt_tx_count: got %h want %h", tx_count, exp_tx_count); else n_pass++;
  endtask

  task automatic test_rx_full();
    logic [7:0] b;
    int rd0, n0, lat;
    rd0 = rd_low_cyc; n0 = rx_got_q.size();
    b = 8'($urandom_range(255, 0));
    rx_full = 1'b1;
    push_rx(b);
    repeat (30) @(negedge clk);
    n_checks++; if (rd_low_cyc - rd0 != 0) $display("FAIL full_blocked: got %0d read cycles want 0", rd_low_cyc - rd0); else n_pass++;
    n_checks++; if (usb_rd_n !== 1'b1) $display("FAIL full_rd_n: got %b want 1", usb_rd_n); else n_pass++;
    rx_full = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!usb_rd_n) begin lat = i; break; end
    end
    n_checks++;
    if (lat < 1 || lat > SYNC_STAGES + 1) $display("FAIL full_release_latency: got %0d cycles want 1..%0d", lat, SYNC_STAGES + 1);
    else n_pass++;
    wait_rx(n0 + 1, "full");
    exp_rx_count = exp_rx_count + 16'd1;
    n_checks++; if (rx_got_q[n0] !== b) $display("FAIL full_data: got %h want %h", rx_got_q[n0], b); else n_pass++;
    n_checks++; if (rx_count !== exp_rx_count) $display("FAIL full_count: got %h want %h", rx_count, exp_rx_count); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int rise0, n0, seen;
    rise0 = wr_rise; n0 = tx_got_q.size();
    push_tx(8'($urandom_range(255, 0)));
    usb_txe_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (usb_wr === 1'b1) begin seen = 1; break; end
    end
    n_checks++; if (seen != 1) $display("FAIL midrst_strobe_seen: got %0d want 1", seen); else n_pass++;
    reset = 1'b1;
    usb_txe_n = 1'b1;
    exp_rx_count = 16'd0;
    exp_tx_count = 16'd0;
    #1;
    n_checks++; if (usb_wr !== 1'b0) $display("FAIL midrst_wr: got %b want 0", usb_wr); else n_pass++;
    n_checks++; if (usb_d_oe !== 1'b0) $display("FAIL midrst_oe: got %b want 0", usb_d_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_count !== exp_tx_count) $display("FAIL midrst_tx_count: got %h want %h", tx_count, exp_tx_count); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (wr_rise - rise0 != 1) $display("FAIL midrst_strobes: got %0d want 1", wr_rise - rise0); else n_pass++;
    n_checks++; if (tx_got_q.size() != n0) $display("FAIL midrst_latched: got %0d bytes want 0", tx_got_q.size() - n0); else n_pass++;
    n_checks++; if (tx_count !== exp_tx_count) $display("FAIL midrst_tx_count_after: got %h want %h", tx_count, exp_tx_count); else n_pass++;
  endtask

  task automatic test_rx_wrap();
    logic [7:0] b [4];
    int n0;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(255, 0));
    @(negedge clk);
    force dut.r_rx_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_rx_count;
    exp_rx_count = 16'hFFFF;
    @(negedge clk);
    n_checks++; if (rx_count !== exp_rx_count) $display("FAIL wrap_preload: got %h want %h", rx_count, exp_rx_count); else n_pass++;
    n0 = rx_got_q.size();
    push_rx(b[0]);
    wait_rx(n0 + 1, "wrap1");
    exp_rx_count = exp_rx_count + 16'd1;
    n_checks++; if (rx_count !== exp_rx_count) $display("FAIL wrap_to_zero: got %h want %h", rx_count, exp_rx_count); else n_pass++;
    for (int i = 1; i < 4; i++) push_rx(b[i]);
    wait_rx(n0 + 4, "wrap3");
    exp_rx_count = exp_rx_count + 16'd3;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_got_q[n0 + i] !== b[i]) $display("FAIL wrap_data_%0d: got %h want %h", i, rx_got_q[n0 + i], b[i]);
      else n_pass++;
    end
    n_checks++; if (rx_count !== exp_rx_count) $display("FAIL wrap_count: got %h want %h", rx_count, exp_rx_count); else n_pass++;
    n_checks++; if (contention != 0) $display("FAIL bus_contention: got %0d cycles want 0", contention); else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    usb_txe_n = 1'b1;
    rx_full   = 1'b0;
    test_reset();
    test_rx_single();
    test_tx_single();
    test_alternate();
    test_rx_full();
    test_reset_mid_write();
    test_rx_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
